// File: rtl/exc_ctrl_pkg.sv
// Purpose: shared exception codes, CP0 bit positions and exception-flag indices
//          used by the MEM-stage exception controller and the CP0 register file.
// Ports:   none (package).
package exc_ctrl_pkg;

   // Exception type codes presented to CP0
   localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
   localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
   localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
   localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
   localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000A;
   localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000C;
   localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000E;

   // CP0 status / cause bit positions
   localparam int unsigned STATUS_IE    = 0;
   localparam int unsigned STATUS_EXL   = 1;
   localparam int unsigned STATUS_IM_LO = 8;
   localparam int unsigned STATUS_IM_HI = 15;
   localparam int unsigned STATUS_BEV   = 22;
   localparam int unsigned CAUSE_IP_LO  = 8;
   localparam int unsigned CAUSE_IP_HI  = 15;

   // exc_flagsM bit indices; ascending index is also descending priority
   localparam int unsigned EXC_FLAGS_W  = 8;
   localparam int unsigned FLAG_ADEL_IF = 0;
   localparam int unsigned FLAG_RI      = 1;
   localparam int unsigned FLAG_SYS     = 2;
   localparam int unsigned FLAG_BP      = 3;
   localparam int unsigned FLAG_OV      = 4;
   localparam int unsigned FLAG_ADEL_LS = 5;
   localparam int unsigned FLAG_ADES    = 6;
   localparam int unsigned FLAG_ERET    = 7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_REDIRECT = 2'd2
   } exc_state_e;

   // Source of the bad virtual address
   typedef enum logic [1:0] {
      BAD_NONE = 2'd0,
      BAD_PC   = 2'd1,
      BAD_DATA = 2'd2
   } bad_sel_e;

   // Exception record handed to CP0 on the commit strobe
   typedef struct packed {
      logic [31:0] exc_type;
      logic [31:0] pc;
      logic        in_ds;
      logic [31:0] badvaddr;
   } exc_rec_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Purpose: combinational priority encoder; selects the winning exception type
//          and the source of the bad virtual address.
// Ports:   flags_i     - per-instruction exception flags
//          int_pend_i  - an enabled interrupt is pending
//          exc_type_o  - EXC_TYPE_* code of the winner (0 when nothing pending)
//          bad_sel_o   - bad_sel_e selector for badvaddr
module exc_prio_enc
   import exc_ctrl_pkg::*;
(
   input  logic [EXC_FLAGS_W-1:0] flags_i,
   input  logic                   int_pend_i,
   output logic [31:0]            exc_type_o,
   output logic [1:0]             bad_sel_o
);

   // Interrupt outranks every synchronous exception
   always_comb begin
      exc_type_o = '0;
      bad_sel_o  = BAD_NONE;
      if (int_pend_i) begin
         exc_type_o = EXC_TYPE_INT;
      end else if (flags_i[FLAG_ADEL_IF]) begin
         exc_type_o = EXC_TYPE_ADEL;
         bad_sel_o  = BAD_PC;
      end else if (flags_i[FLAG_RI]) begin
         exc_type_o = EXC_TYPE_RI;
      end else if (flags_i[FLAG_SYS]) begin
         exc_type_o = EXC_TYPE_SYS;
      end else if (flags_i[FLAG_BP]) begin
         exc_type_o = EXC_TYPE_BP;
      end else if (flags_i[FLAG_OV]) begin
         exc_type_o = EXC_TYPE_OV;
      end else if (flags_i[FLAG_ADEL_LS]) begin
         exc_type_o = EXC_TYPE_ADEL;
         bad_sel_o  = BAD_DATA;
      end else if (flags_i[FLAG_ADES]) begin
         exc_type_o = EXC_TYPE_ADES;
         bad_sel_o  = BAD_DATA;
      end else if (flags_i[FLAG_ERET]) begin
         exc_type_o = EXC_TYPE_ERET;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Purpose: MEM-stage exception controller. Picks the highest-priority event,
//          strobes a one-cycle commit to CP0, flushes the pipeline and holds a
//          fetch redirect until the fetch unit accepts it.
// Ports:   clk, rst (sync, active-high)
//          stallM, validM, pcM, in_dsM, exc_flagsM, data_addrM - MEM instruction
//          status_i, cause_i, epc_i                            - live CP0 state
//          fetch_ready                                         - redirect accept
//          except_en, except_type, exc_pc, exc_in_ds, badvaddr - commit to CP0
//          flush_all, redirect_valid, redirect_pc              - pipeline control
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] VEC_BEV1 = 32'hBFC0_0380,
   parameter logic [31:0] VEC_BEV0 = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallM,
   input  logic        validM,
   input  logic [31:0] pcM,
   input  logic        in_dsM,
   input  logic [7:0]  exc_flagsM,
   input  logic [31:0] data_addrM,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        fetch_ready,
   output logic        except_en,
   output logic [31:0] except_type,
   output logic [31:0] exc_pc,
   output logic        exc_in_ds,
   output logic [31:0] badvaddr,
   output logic        flush_all,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   exc_state_e  state_q, state_d;
   exc_rec_t    rec_q, rec_d;
   logic        bev_q, bev_d;
   logic        except_en_q, except_en_d;
   logic        flush_q, flush_d;
   logic        rv_q, rv_d;
   logic [31:0] rpc_q, rpc_d;

   logic        int_pend;
   logic        take;
   logic [31:0] enc_type;
   logic [1:0]  enc_bad_sel;
   logic [31:0] enc_badvaddr;
   logic        unused_bits;

   assign int_pend = status_i[STATUS_IE] & ~status_i[STATUS_EXL]
                   & (|(status_i[STATUS_IM_HI:STATUS_IM_LO]
                        & cause_i[CAUSE_IP_HI:CAUSE_IP_LO]));

   // An interrupt needs a real instruction to supply the restart PC
   assign take = validM & ~stallM & (int_pend | (|exc_flagsM));

   assign unused_bits = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                          cause_i[31:16], cause_i[7:0]};

   exc_prio_enc u_prio_enc (
      .flags_i    (exc_flagsM),
      .int_pend_i (int_pend),
      .exc_type_o (enc_type),
      .bad_sel_o  (enc_bad_sel)
   );

   // Bad address source mux
   always_comb begin
      case (enc_bad_sel)
         BAD_PC:   enc_badvaddr = pcM;
         BAD_DATA: enc_badvaddr = data_addrM;
         default:  enc_badvaddr = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (take) state_d = ST_COMMIT;
         ST_COMMIT:   state_d = ST_REDIRECT;
         ST_REDIRECT: if (fetch_ready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and latches
   always_comb begin
      rec_d       = '0;
      bev_d       = 1'b0;
      except_en_d = 1'b0;
      flush_d     = 1'b0;
      rv_d        = 1'b0;
      rpc_d       = '0;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               rec_d.exc_type = enc_type;
               rec_d.pc       = pcM;
               rec_d.in_ds    = in_dsM;
               rec_d.badvaddr = enc_badvaddr;
               bev_d          = status_i[STATUS_BEV];
               except_en_d    = 1'b1;
               flush_d        = 1'b1;
            end
         end
         ST_COMMIT: begin
            // EPC is sampled here, the cycle CP0 sees the commit
            rv_d    = 1'b1;
            flush_d = 1'b1;
            if (rec_q.exc_type == EXC_TYPE_ERET) rpc_d = epc_i;
            else if (bev_q)                      rpc_d = VEC_BEV1;
            else                                 rpc_d = VEC_BEV0;
         end
         ST_REDIRECT: begin
            if (!fetch_ready) begin
               rv_d    = 1'b1;
               flush_d = 1'b1;
               rpc_d   = rpc_q;
            end
         end
         default: ;
      endcase
   end

   // Output and latch registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rec_q       <= '0;
         bev_q       <= 1'b0;
         except_en_q <= 1'b0;
         flush_q     <= 1'b0;
         rv_q        <= 1'b0;
         rpc_q       <= '0;
      end else begin
         rec_q       <= rec_d;
         bev_q       <= bev_d;
         except_en_q <= except_en_d;
         flush_q     <= flush_d;
         rv_q        <= rv_d;
         rpc_q       <= rpc_d;
      end
   end

   assign except_en      = except_en_q;
   assign except_type    = rec_q.exc_type;
   assign exc_pc         = rec_q.pc;
   assign exc_in_ds      = rec_q.in_ds;
   assign badvaddr       = rec_q.badvaddr;
   assign flush_all      = flush_q;
   assign redirect_valid = rv_q;
   assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Purpose: scoreboard testbench for exc_ctrl; directed cases followed by
//          randomized traffic checked against a behavioural reference model.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallM, validM, in_dsM, fetch_ready;
   logic [31:0] pcM, data_addrM, status_i, cause_i, epc_i;
   logic [7:0]  exc_flagsM;
   logic        except_en, exc_in_ds, flush_all, redirect_valid;
   logic [31:0] except_type, exc_pc, badvaddr, redirect_pc;

   exc_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stallM         (stallM),
      .validM         (validM),
      .pcM            (pcM),
      .in_dsM         (in_dsM),
      .exc_flagsM     (exc_flagsM),
      .data_addrM     (data_addrM),
      .status_i       (status_i),
      .cause_i        (cause_i),
      .epc_i          (epc_i),
      .fetch_ready    (fetch_ready),
      .except_en      (except_en),
      .except_type    (except_type),
      .exc_pc         (exc_pc),
      .exc_in_ds      (exc_in_ds),
      .badvaddr       (badvaddr),
      .flush_all      (flush_all),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] typ;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] bad;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      int          cyc;
      int          len;
   } red_t;

   exp_t eq[$];
   red_t rq[$];

   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 0;

   // Type code per flag index; lower index = higher priority
   logic [31:0] code_tab [8] = '{32'h4, 32'hA, 32'h8, 32'h9, 32'hC, 32'h4, 32'h5, 32'hE};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: returns 1 when the instruction is taken, with type and badvaddr
   function automatic bit model(input logic v, input logic s, input logic [7:0] f,
                                input logic [31:0] st, input logic [31:0] ca,
                                input logic [31:0] pc, input logic [31:0] da,
                                output logic [31:0] typ, output logic [31:0] bad);
      bit ip;
      ip  = st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 8'h0);
      typ = 32'h0;
      bad = 32'h0;
      if (!(v && !s && (ip || f != 8'h0))) return 0;
      if (ip) begin
         typ = 32'h1;
         return 1;
      end
      for (int i = 0; i < 8; i++) begin
         if (f[i]) begin
            typ = code_tab[i];
            bad = (i == 0) ? pc : ((i == 5 || i == 6) ? da : 32'h0);
            return 1;
         end
      end
      return 1;
   endfunction

   // Random values on every input the DUT must ignore in the current state
   task automatic set_junk(input logic fr);
      validM      = 1'($urandom);
      stallM      = 1'($urandom);
      pcM         = $urandom;
      in_dsM      = 1'($urandom);
      exc_flagsM  = 8'($urandom);
      data_addrM  = $urandom;
      status_i    = $urandom;
      cause_i     = $urandom;
      epc_i       = $urandom;
      fetch_ready = fr;
   endtask

   // Present one MEM cycle; if taken, run the commit/redirect handshake
   task automatic drive(input logic v, input logic s, input logic [31:0] pc,
                        input logic ds, input logic [7:0] f, input logic [31:0] da,
                        input logic [31:0] st, input logic [31:0] ca,
                        input logic [31:0] epc, input int w, input bit rst_mid);
      exp_t        e;
      red_t        r;
      logic [31:0] typ, bad;
      @(posedge clk); #1;
      validM = v; stallM = s; pcM = pc; in_dsM = ds; exc_flagsM = f;
      data_addrM = da; status_i = st; cause_i = ca; epc_i = $urandom;
      fetch_ready = 1'($urandom);
      if (!model(v, s, f, st, ca, pc, da, typ, bad)) return;
      e.typ = typ; e.pc = pc; e.ds = ds; e.bad = bad; e.cyc = cyc + 1;
      eq.push_back(e);
      @(posedge clk); #1;
      set_junk(1'($urandom));
      epc_i = epc;
      r.pc  = (typ == 32'hE) ? epc : (st[22] ? 32'hBFC0_0380 : 32'h8000_0180);
      r.cyc = cyc + 1;
      r.len = rst_mid ? 1 : w + 1;
      rq.push_back(r);
      if (rst_mid) begin
         @(posedge clk); #1; set_junk(1'b0); rst = 1'b1;
         @(posedge clk); #1; set_junk(1'b1);
         @(posedge clk); #1; set_junk(1'b0); validM = 1'b0; rst = 1'b0;
         return;
      end
      for (int i = 0; i < w; i++) begin
         @(posedge clk); #1; set_junk(1'b0);
      end
      @(posedge clk); #1; set_junk(1'b1);
   endtask

   // Monitor: pops expectations whenever the DUT presents a commit or redirect
   bit   rv_prev = 0;
   bit   have_r  = 0;
   red_t rv_cur;
   int   rv_len  = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (except_en) begin
            exp_t e;
            checks++;
            if (eq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_except_en: got type %h pc %h want no commit (cycle %0d)",
                        except_type, exc_pc, cyc);
            end else begin
               e = eq.pop_front();
               chk("commit_cycle", 32'(cyc), 32'(e.cyc));
               chk("except_type", except_type, e.typ);
               chk("exc_pc", exc_pc, e.pc);
               chk("exc_in_ds", 32'(exc_in_ds), 32'(e.ds));
               chk("badvaddr", badvaddr, e.bad);
               chk("flush_in_commit", 32'(flush_all), 32'h1);
            end
         end
         if (redirect_valid) begin
            if (!rv_prev) begin
               checks++;
               if (rq.size() == 0) begin
                  errors++;
                  have_r = 0;
                  $display("FAIL unexpected_redirect: got pc %h want no redirect (cycle %0d)",
                           redirect_pc, cyc);
               end else begin
                  rv_cur = rq.pop_front();
                  have_r = 1;
                  rv_len = 0;
                  chk("redirect_cycle", 32'(cyc), 32'(rv_cur.cyc));
               end
            end
            rv_len++;
            if (have_r) chk("redirect_pc", redirect_pc, rv_cur.pc);
            chk("flush_in_redirect", 32'(flush_all), 32'h1);
         end else if (rv_prev && have_r) begin
            chk("redirect_len", 32'(rv_len), 32'(rv_cur.len));
            have_r = 0;
         end
         if (!except_en && !redirect_valid)
            chk("idle_outputs", 32'({flush_all, exc_in_ds} | (|except_type) | (|exc_pc)
                                   | (|badvaddr) | (|redirect_pc)), 32'h0);
         rv_prev = redirect_valid;
      end
   end

   initial begin
      rst = 1'b1;
      validM = 0; stallM = 0; pcM = 0; in_dsM = 0; exc_flagsM = 0;
      data_addrM = 0; status_i = 0; cause_i = 0; epc_i = 0; fetch_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_except_en", 32'(except_en), 32'h0);
      chk("rst_flush_all", 32'(flush_all), 32'h0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
      chk("rst_except_type", except_type, 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      rst = 1'b0;
      mon_en = 1;

      // Syscall with BEV=1, fetch holds off three cycles
      drive(1, 0, 32'hBFC0_0100, 0, 8'h04, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 3, 0);
      // ri|ov|ades -> RI
      drive(1, 0, 32'h8000_1000, 1, 8'h52, 32'h4444, 32'h0040_0000, 32'h0, 32'h0, 0, 0);
      // adel_ls|ades -> ADEL with data address
      drive(1, 0, 32'h8000_1004, 0, 8'h60, 32'h1235, 32'h0, 32'h0, 32'h0, 1, 0);
      // adel_if -> ADEL with PC
      drive(1, 0, 32'h8000_1003, 0, 8'h01, 32'h9999, 32'h0, 32'h0, 32'h0, 0, 0);
      // Interrupt beats overflow; with EXL set overflow wins
      drive(1, 0, 32'h8000_1008, 0, 8'h10, 32'h0, 32'h0000_0401, 32'h0000_0400, 32'h0, 2, 0);
      drive(1, 0, 32'h8000_100C, 0, 8'h10, 32'h0, 32'h0000_0403, 32'h0000_0400, 32'h0, 0, 0);
      // ERET redirects to EPC; BEV=0 syscall goes to the low vector
      drive(1, 0, 32'h8000_1010, 1, 8'h80, 32'h0, 32'h0040_0000, 32'h0, 32'h8000_2000, 1, 0);
      drive(1, 0, 32'h8000_1014, 0, 8'h04, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      // Stalled breakpoint is held off, then taken once the stall drops
      for (int i = 0; i < 4; i++)
         drive(1, 1, 32'h8000_1018, 0, 8'h08, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      drive(1, 0, 32'h8000_1018, 0, 8'h08, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      // Interrupt withdrawn during a stall is not taken
      drive(1, 1, 32'h8000_101C, 0, 8'h00, 32'h0, 32'h0000_0401, 32'h0000_0400, 32'h0, 0, 0);
      drive(1, 0, 32'h8000_101C, 0, 8'h00, 32'h0, 32'h0000_0400, 32'h0000_0400, 32'h0, 0, 0);
      // Bubble with an interrupt pending is not taken
      drive(0, 0, 32'h8000_1020, 0, 8'h00, 32'h0, 32'h0000_0401, 32'h0000_0400, 32'h0, 0, 0);
      // Reset while redirecting, then a normal exception right after
      drive(1, 0, 32'h8000_1024, 0, 8'h08, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 0, 1);
      drive(1, 0, 32'h8000_1028, 0, 8'h04, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         logic [31:0] st;
         logic [7:0]  f;
         st = $urandom;
         if ($urandom_range(0, 1) == 0) st[1:0] = 2'b01;
         f = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom & $urandom & $urandom);
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 5) == 0), $urandom,
               1'($urandom), f, $urandom, st, $urandom, $urandom,
               int'($urandom_range(0, 3)), 0);
      end

      @(posedge clk); #1;
      validM = 0; exc_flagsM = 0; stallM = 0; fetch_ready = 0;
      repeat (6) @(posedge clk);
      #1;
      chk("commit_queue_drained", 32'(eq.size()), 32'h0);
      chk("redirect_queue_drained", 32'(rq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
MEM-stage exception controller, sitting directly upstream of the CP0 register file. Each cycle it takes the per-instruction exception flags of the MEM instruction and the live CP0 status/cause/epc. It picks the highest-priority event and issues a one-cycle commit strobe with type, PC, delay-slot flag and bad address to CP0. It then flushes the pipeline and holds a fetch redirect (handler vector or EPC) until the fetch unit accepts it.

Parameters:
VEC_BEV1, 32'hBFC0_0380, handler address when status.BEV=1
VEC_BEV0, 32'h8000_0180, handler address when status.BEV=0

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallM  in  1  MEM stage stalled; no exception may be taken this cycle
validM  in  1  MEM holds a real (not bubble/flushed) instruction
pcM  in  32  MEM instruction PC
in_dsM  in  1  MEM instruction is in a branch delay slot
exc_flagsM  in  8  {eret, ades, adel_ls, ov, bp, sys, ri, adel_if}
data_addrM  in  32  load/store effective address
status_i  in  32  CP0 status
cause_i  in  32  CP0 cause
epc_i  in  32  CP0 EPC
fetch_ready  in  1  fetch unit accepts redirect this cycle
except_en  out  1  one-cycle commit strobe to CP0
except_type  out  32  EXC_TYPE_* code to CP0
exc_pc  out  32  faulting PC to CP0
exc_in_ds  out  1  delay-slot flag to CP0
badvaddr  out  32  bad virtual address to CP0
flush_all  out  1  flush IF..MEM
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target

Behaviour:
- Reset: state IDLE. All outputs 0. Internal latches 0.
- int_pend = status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]).
- Priority, high to low: INT, ADEL(if), RI, SYS, BP, OV, ADEL(ls), ADES, ERET. Exactly one type is selected.
- badvaddr: pcM for ADEL(if); data_addrM for ADEL(ls)/ADES; 0 otherwise.
- take = validM & ~stallM & (int_pend | |exc_flagsM). INT is taken only with validM=1, because a PC is required.
- IDLE: on take, latch type, pcM, in_dsM, badvaddr and BEV (status_i[22]); go to COMMIT. Otherwise stay; outputs 0.
- COMMIT (exactly 1 cycle):
  - except_en=1, flush_all=1; the type/pc/ds/badvaddr outputs present the latched values.
  - redirect target latched here: epc_i if type=ERET; otherwise VEC_BEV1 if latched BEV=1, else VEC_BEV0.
  - Go to REDIRECT.
- REDIRECT:
  - except_en=0, flush_all=1, redirect_valid=1, redirect_pc stable.
  - On fetch_ready=1, go to IDLE; redirect_valid and flush_all drop the next cycle.
  - fetch_ready is ignored outside REDIRECT.
- Latency: take in cycle t; except_en in t+1; redirect_valid from t+2 until it is accepted. Minimum take-to-IDLE is 3 cycles.
- validM/exc_flagsM are ignored in COMMIT and REDIRECT; those instructions are being flushed.
- stallM=1 with a pending exception: nothing is taken and nothing is latched. It is re-evaluated every cycle, so an interrupt that is withdrawn during the stall is not taken.
- Simultaneous interrupt and synchronous exception: INT wins; EPC is the instruction PC, and the instruction restarts.
- Reset asserted in any state: IDLE next cycle, outputs 0. A partial commit is abandoned.
- except_in_ds is forwarded unchanged; CP0 does the EPC-4 adjustment.

Decomposition:
- Shared defines: EXC_TYPE_* codes: INT=32'h1, ADEL=32'h4, ADES=32'h5, SYS=32'h8, BP=32'h9, RI=32'hA, OV=32'hC, ERET=32'hE. Also status/cause bit-position defines (IE, EXL, BEV, IM, IP) and the exc_flags bit indices. These are shared with the CP0 register file.
- One combinational sub-module, exc_prio_enc: flags + int_pend → type + badvaddr select. The FSM and latches stay in exc_ctrl.

Test Plan:
- Syscall: validM=1, pcM=0xBFC0_0100, flags=sys, status=0x0040_0000 → except_en in t+1 with type 8 and exc_pc 0xBFC0_0100; redirect_pc=0xBFC0_0380 held; fetch_ready low for 3 cycles, then high → IDLE the cycle after acceptance.
- Priority: flags ri|ov|ades together → type 0xA. Flags adel_ls|ades with data_addrM=0x1235 → type 4, badvaddr 0x1235.
- Interrupt: status=0x0000_0401, cause IP2=1, flags=ov → type 1 (INT wins). With status.EXL=1 instead → type 0xC.
- ERET: flags=eret, epc_i=0x8000_2000 → type 0xE; redirect_pc=0x8000_2000. BEV=0 syscall case → redirect_pc 0x8000_0180.
- Stall: flags=bp with stallM=1 for 4 cycles → no except_en. stallM drops → except_en the next cycle.
- Reset in REDIRECT, and validM=0 with int_pend=1 → outputs 0, state IDLE, nothing taken.
